// File: rtl/stego_sample_sched.sv
// Sample scheduler: buffers samples in a circular FIFO, issues one at a time to the embedder
// with FRAME_SIZE message bits. Optional watchdog under `STEGO_SCHED_WATCHDOG_EN`.
module stego_sample_sched #(
    parameter int unsigned BPS        = 16,
    parameter int unsigned FRAME_SIZE = 1,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  in_clk,
    input  logic                  in_rst_n,
    input  logic                  in_sample_valid,
    input  logic [BPS-1:0]        in_sample,
    input  logic                  in_msg_valid,
    input  logic [7:0]            in_msg_byte,
    output logic                  out_msg_ready,
    input  logic                  in_sample_sent,
    output logic                  out_enable,
    output logic [BPS-1:0]        out_frame,
    output logic [FRAME_SIZE-1:0] out_message,
    output logic                  out_embed,
    output logic [DEPTH_LOG2:0]   out_level,
    output logic                  out_overflow,
    output logic [15:0]           out_embed_count
`ifdef STEGO_SCHED_WATCHDOG_EN
    ,
    output logic                  out_timeout
`endif
);

    localparam int unsigned Depth = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] PtrOne = 1;
    localparam logic [DEPTH_LOG2:0]   LvlOne = 1;
    localparam logic [3:0]            FsBits = 4'(FRAME_SIZE);

    typedef enum logic [1:0] {StIdle, StLoad, StIssue, StWait} state_e;

    state_e                  state_q, state_d;
    logic [BPS-1:0]          mem_q [Depth];
    logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]     level_q, level_d;
    logic                    overflow_q, overflow_d;
    logic [7:0]              msg_q, msg_d;
    logic [3:0]              bits_q, bits_d;
    logic [BPS-1:0]          frame_q, frame_d;
    logic [FRAME_SIZE-1:0]   message_q, message_d;
    logic                    embed_q, embed_d;
    logic                    enable_q, enable_d;
    logic [15:0]             embed_cnt_q, embed_cnt_d;
    logic                    full, wr_en, rd_en, msg_accept;
`ifdef STEGO_SCHED_WATCHDOG_EN
    logic [15:0]             wd_q, wd_d;
    logic                    timeout_q, timeout_d;
`endif

    // Level never exceeds Depth, so the MSB alone flags a full FIFO.
    assign full          = level_q[DEPTH_LOG2];
    assign out_msg_ready = (bits_q == 4'd0);
    assign msg_accept    = in_msg_valid && out_msg_ready;

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        overflow_d  = overflow_q;
        msg_d       = msg_q;
        bits_d      = bits_q;
        frame_d     = frame_q;
        message_d   = message_q;
        embed_d     = embed_q;
        enable_d    = 1'b0;
        embed_cnt_d = embed_cnt_q;
        rd_en       = 1'b0;
`ifdef STEGO_SCHED_WATCHDOG_EN
        wd_d        = wd_q;
        timeout_d   = timeout_q;
`endif

        wr_en = in_sample_valid && !full;
        if (in_sample_valid && full) begin
            overflow_d = 1'b1;
        end

        // Acceptance needs an empty counter and consumption a nonzero one, so they never collide.
        if (msg_accept) begin
            msg_d  = in_msg_byte;
            bits_d = 4'd8;
        end

        unique case (state_q)
            StIdle: begin
                if (level_q != '0) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                rd_en   = 1'b1;
                frame_d = mem_q[rd_ptr_q];
                if (bits_q != 4'd0) begin
                    message_d = msg_q[7 -: FRAME_SIZE];
                    embed_d   = 1'b1;
                    msg_d     = msg_q << FRAME_SIZE;
                    bits_d    = bits_q - FsBits;
                end else begin
                    message_d = '0;
                    embed_d   = 1'b0;
                end
                enable_d = 1'b1;
                state_d  = StIssue;
            end
            StIssue: begin
                if (embed_q) begin
                    embed_cnt_d = embed_cnt_q + 16'd1;
                end
`ifdef STEGO_SCHED_WATCHDOG_EN
                wd_d = '0;
`endif
                state_d = StWait;
            end
            StWait: begin
                if (in_sample_sent) begin
                    state_d = StIdle;
`ifdef STEGO_SCHED_WATCHDOG_EN
                end else if (wd_q == 16'hFFFF) begin
                    state_d   = StIdle;
                    timeout_d = 1'b1;
                end else begin
                    wd_d = wd_q + 16'd1;
`endif
                end
            end
        endcase

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PtrOne;
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + PtrOne;
        end
        case ({wr_en, rd_en})
            2'b10:   level_d = level_q + LvlOne;
            2'b01:   level_d = level_q - LvlOne;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge in_clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= in_sample;
        end
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            msg_q       <= '0;
            bits_q      <= '0;
            frame_q     <= '0;
            message_q   <= '0;
            embed_q     <= 1'b0;
            enable_q    <= 1'b0;
            embed_cnt_q <= '0;
`ifdef STEGO_SCHED_WATCHDOG_EN
            wd_q        <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            msg_q       <= msg_d;
            bits_q      <= bits_d;
            frame_q     <= frame_d;
            message_q   <= message_d;
            embed_q     <= embed_d;
            enable_q    <= enable_d;
            embed_cnt_q <= embed_cnt_d;
`ifdef STEGO_SCHED_WATCHDOG_EN
            wd_q        <= wd_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

    assign out_enable      = enable_q;
    assign out_frame       = frame_q;
    assign out_message     = message_q;
    assign out_embed       = embed_q;
    assign out_level       = level_q;
    assign out_overflow    = overflow_q;
    assign out_embed_count = embed_cnt_q;
`ifdef STEGO_SCHED_WATCHDOG_EN
    assign out_timeout     = timeout_q;
`endif

endmodule

// File: tb/tb_stego_sample_sched.sv
// Scoreboard bench for stego_sample_sched: a queue/bit-list reference model predicts each issued
// sample; a monitor pops and compares on every out_enable pulse.
module tb_stego_sample_sched;

    localparam int unsigned BPS   = 16;
    localparam int unsigned FS    = 1;
    localparam int unsigned DL    = 4;
    localparam int unsigned Depth = 1 << DL;

    logic           in_clk = 1'b0;
    logic           in_rst_n = 1'b0;
    logic           in_sample_valid = 1'b0;
    logic [BPS-1:0] in_sample = '0;
    logic           in_msg_valid = 1'b0;
    logic [7:0]     in_msg_byte = '0;
    logic           out_msg_ready;
    logic           in_sample_sent = 1'b0;
    logic           out_enable;
    logic [BPS-1:0] out_frame;
    logic [FS-1:0]  out_message;
    logic           out_embed;
    logic [DL:0]    out_level;
    logic           out_overflow;
    logic [15:0]    out_embed_count;
`ifdef STEGO_SCHED_WATCHDOG_EN
    logic           out_timeout;
`endif

    stego_sample_sched #(
        .BPS        (BPS),
        .FRAME_SIZE (FS),
        .DEPTH_LOG2 (DL)
    ) dut (
        .in_clk          (in_clk),
        .in_rst_n        (in_rst_n),
        .in_sample_valid (in_sample_valid),
        .in_sample       (in_sample),
        .in_msg_valid    (in_msg_valid),
        .in_msg_byte     (in_msg_byte),
        .out_msg_ready   (out_msg_ready),
        .in_sample_sent  (in_sample_sent),
        .out_enable      (out_enable),
        .out_frame       (out_frame),
        .out_message     (out_message),
        .out_embed       (out_embed),
        .out_level       (out_level),
        .out_overflow    (out_overflow),
        .out_embed_count (out_embed_count)
`ifdef STEGO_SCHED_WATCHDOG_EN
        ,
        .out_timeout     (out_timeout)
`endif
    );

    always #5 in_clk = ~in_clk;

    typedef struct {
        logic [BPS-1:0] frame;
        logic           embed;
        logic [FS-1:0]  msg;
        logic [15:0]    cnt;
    } exp_t;

    exp_t        exp_q[$];
    bit          m_bits[$];
    logic [15:0] m_cnt = '0;
    logic        m_ovf = 1'b0;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Reference model: the next issued sample takes the next FS message bits, if any remain.
    task automatic push_expected(input logic [BPS-1:0] s);
        exp_t e;
        e.frame = s;
        e.msg   = '0;
        if (m_bits.size() > 0) begin
            e.embed = 1'b1;
            for (int i = 0; i < FS; i++) begin
                e.msg = (e.msg << 1) | FS'(m_bits.pop_front());
            end
            m_cnt = m_cnt + 16'd1;
        end else begin
            e.embed = 1'b0;
        end
        e.cnt = m_cnt;
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge in_clk);
            if (out_enable === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_enable", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("frame", 32'(out_frame), 32'(e.frame));
                    check("embed", 32'(out_embed), 32'(e.embed));
                    check("message", 32'(out_message), 32'(e.msg));
                    @(negedge in_clk);
                    check("embed_count", 32'(out_embed_count), 32'(e.cnt));
                end
            end
        end
    end

    task automatic offer_byte(input logic [7:0] b);
        check("msg_ready_before", 32'(out_msg_ready), 32'(m_bits.size() == 0));
        in_msg_valid = 1'b1;
        in_msg_byte  = b;
        @(negedge in_clk);
        in_msg_valid = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            m_bits.push_back(b[i]);
        end
        check("msg_ready_after", 32'(out_msg_ready), 32'd0);
    endtask

    // Write n samples into an idle, empty scheduler; one is issued and Depth more fit.
    task automatic write_burst(input int n, output int acc);
        logic [BPS-1:0] s;
        acc = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge in_clk);
            s = BPS'($urandom);
            in_sample_valid = 1'b1;
            in_sample       = s;
            if (acc < int'(Depth) + 1) begin
                push_expected(s);
                acc++;
            end else begin
                m_ovf = 1'b1;
            end
        end
        @(negedge in_clk);
        in_sample_valid = 1'b0;
        repeat (3) @(negedge in_clk);
        check("burst_level", 32'(out_level), 32'(acc - 1));
        check("burst_overflow", 32'(out_overflow), 32'(m_ovf));
    endtask

    task automatic wait_enable(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge in_clk);
            if (out_enable === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic pulse_sent();
        repeat ($urandom_range(1, 4)) @(negedge in_clk);
        in_sample_sent = 1'b1;
        @(negedge in_clk);
        in_sample_sent = 1'b0;
    endtask

    // The first sample of a burst is already in WAIT; acknowledge it and each later issue.
    task automatic drain(input int acc);
        bit ok;
        for (int k = 0; k < acc; k++) begin
            if (k > 0) begin
                wait_enable(ok);
                if (!ok) begin
                    fail_now("drain_enable");
                    break;
                end
            end
            pulse_sent();
        end
        repeat (4) @(negedge in_clk);
        check("drain_level", 32'(out_level), 32'd0);
        check("drain_msg_ready", 32'(out_msg_ready), 32'(m_bits.size() == 0));
        check("drain_embed_count", 32'(out_embed_count), 32'(m_cnt));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_enable"}, 32'(out_enable), 32'd0);
        check({tag, "_frame"}, 32'(out_frame), 32'd0);
        check({tag, "_embed"}, 32'(out_embed), 32'd0);
        check({tag, "_message"}, 32'(out_message), 32'd0);
        check({tag, "_level"}, 32'(out_level), 32'd0);
        check({tag, "_overflow"}, 32'(out_overflow), 32'd0);
        check({tag, "_count"}, 32'(out_embed_count), 32'd0);
        check({tag, "_msg_ready"}, 32'(out_msg_ready), 32'd1);
`ifdef STEGO_SCHED_WATCHDOG_EN
        check({tag, "_timeout"}, 32'(out_timeout), 32'd0);
`endif
    endtask

    initial begin : stimulus
        int  acc;
        bit  ok;
        bit  idle_quiet;

        repeat (3) @(negedge in_clk);
        check_reset_state("por");
        in_rst_n = 1'b1;
        @(negedge in_clk);

        // Plain sample, no message: enable two edges after the write.
        in_sample_valid = 1'b1;
        in_sample       = 16'h1234;
        push_expected(16'h1234);
        @(negedge in_clk);
        in_sample_valid = 1'b0;
        @(negedge in_clk);
        check("latency_edge1", 32'(out_enable), 32'd0);
        @(negedge in_clk);
        check("latency_edge2", 32'(out_enable), 32'd1);
        drain(1);

        // 0xA5 spread over eight samples; the ninth passes through.
        offer_byte(8'hA5);
        write_burst(9, acc);
        drain(acc);
        check("a5_embed_count", 32'(out_embed_count), 32'd8);

        // Exactly fills the FIFO behind the issued sample.
        write_burst(17, acc);
        check("fill_level16", 32'(out_level), 32'd16);
        drain(acc);

        // Stray sent pulse while idle and empty.
        in_sample_sent = 1'b1;
        @(negedge in_clk);
        in_sample_sent = 1'b0;
        idle_quiet = 1'b1;
        repeat (8) begin
            @(negedge in_clk);
            if (out_enable !== 1'b0) idle_quiet = 1'b0;
        end
        check("idle_sent_quiet", 32'(idle_quiet), 32'd1);
        check("idle_sent_level", 32'(out_level), 32'd0);

        for (int it = 0; it < 8; it++) begin
            if (m_bits.size() == 0 && $urandom_range(0, 1) == 1) begin
                offer_byte(8'($urandom));
            end
            write_burst(int'($urandom_range(1, 20)), acc);
            drain(acc);
        end

        write_burst(18, acc);
        check("ovf_level", 32'(out_level), 32'd16);
        check("ovf_flag", 32'(out_overflow), 32'd1);
        drain(acc);

        // Reset in WAIT with five samples buffered.
        if (m_bits.size() == 0) offer_byte(8'h3C);
        write_burst(6, acc);
        in_rst_n = 1'b0;
        #1;
        check_reset_state("midrst");
        exp_q.delete();
        m_bits.delete();
        m_cnt = '0;
        m_ovf = 1'b0;
        repeat (2) @(negedge in_clk);
        in_rst_n = 1'b1;
        write_burst(1, acc);
        drain(acc);

`ifdef STEGO_SCHED_WATCHDOG_EN
        write_burst(2, acc);
        ok = 1'b0;
        for (int i = 0; i < 70000; i++) begin
            @(negedge in_clk);
            if (out_timeout === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        check("wd_timeout", 32'(ok), 32'd1);
        wait_enable(ok);
        check("wd_next_issue", 32'(ok), 32'd1);
        if (ok) pulse_sent();
        repeat (4) @(negedge in_clk);
        check("wd_level", 32'(out_level), 32'd0);
        check("wd_sticky", 32'(out_timeout), 32'd1);
`endif

        repeat (4) @(negedge in_clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/stego_sample_sched.md
# stego_sample_sched

Sample scheduler between `uart2sample` and `bit_changer_seq`. It buffers received audio samples in an internal circular FIFO and serializes hidden-message bytes into FRAME_SIZE-bit chunks. It issues exactly one sample at a time to the embedder, then holds the next one until the UART transmit path reports that the previous sample has been fully sent. This replaces direct `u2s_ready → bit_changer` wiring and the unused FIFO instance in the top level.

## Interface
Parameters:
- `BPS`, 16, bits per sample.
- `FRAME_SIZE`, 1, message bits embedded per sample. Legal values: 1, 2, 4, 8.
- `DEPTH_LOG2`, 4, FIFO depth = 2^DEPTH_LOG2 samples.

Ports:
- `in_clk`  in  1  clock.
- `in_rst_n`  in  1  reset; asynchronous, active-low.
- `in_sample_valid`  in  1  one-cycle pulse; `in_sample` is valid.
- `in_sample`  in  BPS  received sample.
- `in_msg_valid`  in  1  message byte offered.
- `in_msg_byte`  in  8  message byte.
- `out_msg_ready`  out  1  byte accepted on the cycle `in_msg_valid` and `out_msg_ready` are both high.
- `in_sample_sent`  in  1  one-cycle pulse; the last UART byte of the issued sample has finished transmitting.
- `out_enable`  out  1  one-cycle pulse to the `bit_changer_seq` enable input.
- `out_frame`  out  BPS  sample to the embedder.
- `out_message`  out  FRAME_SIZE  bits to embed.
- `out_embed`  out  1  1: `out_message` is valid; 0: the sample passes through unmodified (`out_message` = 0).
- `out_level`  out  DEPTH_LOG2+1  FIFO occupancy.
- `out_overflow`  out  1  sticky; set when a sample is dropped.
- `out_embed_count`  out  16  number of samples issued with `out_embed`=1; wraps at 65535→0.
- `out_timeout`  out  1  sticky watchdog flag; present only with the macro defined.

## Operation
FIFO:
- Write on `in_sample_valid` when `out_level` < 2^DEPTH_LOG2.
- When full, the write is dropped and `out_overflow` is set. This holds even if a read happens on the same cycle.
- Write and read pointers wrap modulo 2^DEPTH_LOG2.

Message buffer:
- 8-bit shift register plus a bit counter.
- `out_msg_ready` = 1 whenever the counter is 0.
- On acceptance, the byte is loaded and the counter is set to 8.
- Each embedded issue consumes the top FRAME_SIZE bits, MSB first: shift left by FRAME_SIZE and decrement the counter by FRAME_SIZE.

FSM:
- IDLE → LOAD when the FIFO is not empty.
- LOAD: pop the FIFO head into `out_frame`. If the bit counter is nonzero, latch the top chunk into `out_message`, set `out_embed`=1 and consume the chunk; otherwise set `out_embed`=0 and `out_message`=0. Go to ISSUE.
- ISSUE: `out_enable`=1 for one cycle; increment `out_embed_count` if `out_embed`=1. Go to WAIT.
- WAIT: on `in_sample_sent` → IDLE. `in_sample_sent` pulses seen in any other state are ignored.

Other rules:
- A byte accepted on the same edge as LOAD is not used by that LOAD. It is first used by the next sample.
- `out_frame`, `out_message` and `out_embed` hold their values from LOAD until the next LOAD.

Reset:
- All outputs are 0, except `out_msg_ready`=1.
- FIFO is empty, bit counter is 0, FSM is in IDLE.
- Reset asserted mid-operation aborts the in-flight sample. Buffered samples and the partial message byte are discarded.

## Timing
- `out_level` updates on the edge after a write or read.
- The first sample written into an empty FIFO on edge 0 causes IDLE→LOAD at edge 1 and ISSUE at edge 2, so `out_enable` is high during cycle 2–3. Sample-to-enable latency is 2 cycles.
- Back-to-back throughput: one sample per (`in_sample_sent` latency + 3) cycles.
- `out_msg_ready` deasserts on the edge after acceptance and reasserts on the edge after the last chunk is consumed.

## Configuration
- `STEGO_SCHED_WATCHDOG_EN` defined:
  - A 16-bit counter runs while in WAIT.
  - If it reaches 65535 without `in_sample_sent`, the FSM goes to IDLE and `out_timeout` is set (sticky until reset).
  - The counter clears when entering WAIT.
- Not defined: the counter and `out_timeout` are absent, and WAIT waits indefinitely.

## Test plan
- Reset, then one sample 0x1234 with no message → `out_enable` pulse 2 cycles later, `out_frame`=0x1234, `out_embed`=0, `out_embed_count`=0.
- FRAME_SIZE=1: byte 0xA5, then 9 samples each acknowledged by `in_sample_sent` → `out_message` sequence 1,0,1,0,0,1,0,1, with `out_embed`=1 on those 8; 9th sample `out_embed`=0; `out_embed_count`=8; `out_msg_ready` reasserts after the 8th LOAD.
- DEPTH_LOG2=4: 17 samples with no `in_sample_sent` → first sample issued, next 16 buffered, `out_level`=16, `out_overflow`=0; an 18th sample is dropped, `out_overflow`=1; draining yields FIFO order with no loss of the buffered 16.
- `in_sample_sent` pulsed while in IDLE with the FIFO empty → no state change, no `out_enable`.
- Reset asserted in WAIT with `out_level`=5 → all outputs 0 immediately (except `out_msg_ready`=1), `out_level`=0; the next sample after release is issued normally.
- With `STEGO_SCHED_WATCHDOG_EN`: issue a sample and never pulse `in_sample_sent` → after 65535 WAIT cycles `out_timeout`=1 and FSM returns to IDLE; the next buffered sample issues.
